// File: rtl/env_pkg.sv
// Shared types and helpers for the per-voice ADSR envelope stage.
package env_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [15:0] LEVEL_MAX = 16'hFFFF;

    // Envelope step for one pulse: (rate + 1) << shift, clamped to the 17-bit arithmetic range.
    function automatic logic [16:0] rate_step(input logic [7:0] rate, input int shift);
        logic [39:0] wide;
        wide = (40'(rate) + 40'd1) << shift;
        if (|wide[39:17]) begin
            return 17'h1FFFF;
        end
        return wide[16:0];
    endfunction

endpackage

// File: rtl/env_adsr_if.sv
// Sample / control / result bundle between the tone generator, the envelope stage and the mixer.
interface env_adsr_if;
    import env_pkg::*;

    logic         i_pulse;
    logic [15:0]  i_sample;
    logic         i_gate;
    logic [7:0]   i_attack;
    logic [7:0]   i_decay;
    logic [7:0]   i_sustain;
    logic [7:0]   i_release;
    logic [15:0]  o_sample;
    logic         o_valid;
    state_t       o_state;
    logic         o_busy;

    modport master (
        output i_pulse, i_sample, i_gate, i_attack, i_decay, i_sustain, i_release,
        input  o_sample, o_valid, o_state, o_busy
    );

    modport slave (
        input  i_pulse, i_sample, i_gate, i_attack, i_decay, i_sustain, i_release,
        output o_sample, o_valid, o_state, o_busy
    );

endinterface

// File: rtl/env_scale.sv
// Output pipeline of the envelope: signed sample times unsigned level, upper half registered,
// with a matching valid strobe.
module env_scale (
    input  logic               i_clk48,
    input  logic               i_rst48,
    input  logic               i_valid,
    input  logic signed [15:0] i_s,
    input  logic [15:0]        i_level,
    output logic [15:0]        o_sample,
    output logic               o_valid
);

    logic signed [32:0] s_ext;
    logic signed [32:0] level_ext;
    logic signed [32:0] product;
    logic [15:0]        sample_q;
    logic               valid_q;

    // The level is zero-extended so 0xFFFF stays positive (unity gain) in the signed multiply.
    always_comb begin
        s_ext     = 33'(i_s);
        level_ext = $signed({17'd0, i_level});
        product   = s_ext * level_ext;
    end

    // NOTE: the output registers are reset so a reset mid-stream leaves no stale sample or strobe.
    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= i_valid;
            if (i_valid) begin
                sample_q <= 16'(product >>> 16);
            end
        end
    end

    assign o_sample = sample_q;
    assign o_valid  = valid_q;

endmodule

// File: rtl/env_adsr.sv
// Per-voice ADSR envelope: steps a 16-bit level once per sample strobe and scales the
// generator sample by it.
module env_adsr
    import env_pkg::*;
#(
    parameter int RATE_SHIFT = 0
) (
    input  logic       i_clk48,
    input  logic       i_rst48,
    env_adsr_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_ATTACK  = ATTACK;
    localparam logic [2:0] S_DECAY   = DECAY;
    localparam logic [2:0] S_SUSTAIN = SUSTAIN;
    localparam logic [2:0] S_RELEASE = RELEASE;

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [15:0]        level_q;
    logic [15:0]        level_d;
    logic [15:0]        s_q;
    logic               pulse_q;

    logic [16:0]        step_a;
    logic [16:0]        step_d;
    logic [16:0]        step_r;
    logic [15:0]        target;
    logic [17:0]        atk_sum;
    logic signed [17:0] dec_diff;
    logic signed [17:0] rel_diff;

    // 18-bit intermediates leave headroom for the largest clamped step, so nothing wraps.
    always_comb begin
        step_a   = rate_step(bus.i_attack, RATE_SHIFT);
        step_d   = rate_step(bus.i_decay, RATE_SHIFT);
        step_r   = rate_step(bus.i_release, RATE_SHIFT);
        target   = {bus.i_sustain, bus.i_sustain};
        atk_sum  = {2'b00, level_q} + {1'b0, step_a};
        dec_diff = $signed({2'b00, level_q}) - $signed({1'b0, step_d});
        rel_diff = $signed({2'b00, level_q}) - $signed({1'b0, step_r});
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (bus.i_pulse) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_gate) begin
                        state_d = S_ATTACK;
                    end
                end
                S_ATTACK: begin
                    if (!bus.i_gate) begin
                        state_d = S_RELEASE;
                    end else if (atk_sum >= {2'b00, LEVEL_MAX}) begin
                        level_d = LEVEL_MAX;
                        state_d = S_DECAY;
                    end else begin
                        level_d = atk_sum[15:0];
                    end
                end
                S_DECAY: begin
                    if (!bus.i_gate) begin
                        state_d = S_RELEASE;
                    end else if (dec_diff <= $signed({2'b00, target})) begin
                        level_d = target;
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = dec_diff[15:0];
                    end
                end
                S_SUSTAIN: begin
                    if (!bus.i_gate) begin
                        state_d = S_RELEASE;
                    end else begin
                        level_d = target;
                    end
                end
                S_RELEASE: begin
                    if (bus.i_gate) begin
                        state_d = S_ATTACK;
                    end else if (rel_diff <= 18'sd0) begin
                        level_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        level_d = rel_diff[15:0];
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    level_d = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            state_q <= S_IDLE;
            level_q <= '0;
            s_q     <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            pulse_q <= bus.i_pulse;
            if (bus.i_pulse) begin
                s_q <= {~bus.i_sample[15], bus.i_sample[14:0]};
            end
        end
    end

    // level_q already holds the post-pulse level when pulse_q is high.
    env_scale u_scale (
        .i_clk48  (i_clk48),
        .i_rst48  (i_rst48),
        .i_valid  (pulse_q),
        .i_s      (s_q),
        .i_level  (level_q),
        .o_sample (bus.o_sample),
        .o_valid  (bus.o_valid)
    );

    assign bus.o_state = state_t'(state_q);
    assign bus.o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_env_adsr.sv
// Self-checking bench for env_adsr: behavioural envelope model feeding a scoreboard of
// expected samples and arrival cycles, plus directed checks of the documented values.
module tb_env_adsr;
    import env_pkg::*;

    localparam int SHIFT = 0;

    logic i_clk48 = 1'b0;
    logic i_rst48 = 1'b1;

    env_adsr_if bus ();

    env_adsr #(.RATE_SHIFT(SHIFT)) dut (
        .i_clk48 (i_clk48),
        .i_rst48 (i_rst48),
        .bus     (bus)
    );

    always #10 i_clk48 = ~i_clk48;

    int cyc = 0;
    always @(posedge i_clk48) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] smp;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [15:0] last_sample  = '0;

    state_t m_st  = IDLE;
    int     m_lvl = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Sample is offset binary; subtracting the midpoint gives its signed value.
    function automatic logic [15:0] exp_out(input logic [15:0] smp, input int lvl);
        longint      p;
        logic [63:0] q;
        p = (longint'(smp) - 64'sd32768) * longint'(lvl);
        q = p >>> 16;
        return q[15:0];
    endfunction

    function automatic int m_step(input logic [7:0] r);
        return (int'(r) + 1) << SHIFT;
    endfunction

    task automatic model_pulse();
        int tgt;
        tgt = int'(bus.i_sustain) * 257;
        if (m_st == IDLE) begin
            if (bus.i_gate) m_st = ATTACK;
        end else if (m_st != RELEASE && !bus.i_gate) begin
            m_st = RELEASE;
        end else if (m_st == ATTACK) begin
            if (m_lvl + m_step(bus.i_attack) >= 65535) begin
                m_lvl = 65535;
                m_st  = DECAY;
            end else begin
                m_lvl = m_lvl + m_step(bus.i_attack);
            end
        end else if (m_st == DECAY) begin
            if (m_lvl - m_step(bus.i_decay) <= tgt) begin
                m_lvl = tgt;
                m_st  = SUSTAIN;
            end else begin
                m_lvl = m_lvl - m_step(bus.i_decay);
            end
        end else if (m_st == SUSTAIN) begin
            m_lvl = tgt;
        end else begin
            if (bus.i_gate) begin
                m_st = ATTACK;
            end else if (m_lvl - m_step(bus.i_release) <= 0) begin
                m_lvl = 0;
                m_st  = IDLE;
            end else begin
                m_lvl = m_lvl - m_step(bus.i_release);
            end
        end
    endtask

    // Called #1 after a rising edge; gap = clocks from this pulse to the next call's pulse.
    task automatic do_pulse(input int gap);
        int t;
        t = cyc;
        bus.i_pulse = 1'b1;
        @(posedge i_clk48);
        #1;
        bus.i_pulse = 1'b0;
        model_pulse();
        sb.push_back('{smp: exp_out(bus.i_sample, m_lvl), due: t + 2});
        check("o_state", 32'(bus.o_state), 32'(m_st));
        check("o_busy", {31'd0, bus.o_busy}, {31'd0, m_st != IDLE});
        repeat (gap - 1) begin
            @(posedge i_clk48);
            #1;
        end
    endtask

    task automatic drain();
        repeat (3) begin
            @(posedge i_clk48);
            #1;
        end
    endtask

    always @(negedge i_clk48) begin
        if (bus.o_valid === 1'b1) begin
            last_sample = bus.o_sample;
            if (sb.size() == 0) begin
                check("spurious_valid", {31'd0, bus.o_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("o_sample", {16'd0, bus.o_sample}, {16'd0, e.smp});
                check("latency", cyc, e.due);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.i_pulse   = 1'b0;
        bus.i_sample  = 16'h0000;
        bus.i_gate    = 1'b0;
        bus.i_attack  = 8'd0;
        bus.i_decay   = 8'd0;
        bus.i_sustain = 8'd0;
        bus.i_release = 8'd0;
        i_rst48       = 1'b1;
        repeat (3) @(posedge i_clk48);
        #1;
        check("rst_state", 32'(bus.o_state), 32'(IDLE));
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_sample", {16'd0, bus.o_sample}, 32'd0);
        i_rst48 = 1'b0;
        @(posedge i_clk48);
        #1;

        // Idle with gate low: outputs still produced, all zero.
        bus.i_sample = 16'h1234;
        repeat (10) do_pulse(2);
        drain();
        check("idle_sample", {16'd0, last_sample}, 32'd0);

        // Attack at full rate, back-to-back pulses.
        bus.i_sample = 16'hFFFF;
        bus.i_attack = 8'd255;
        bus.i_decay  = 8'd255;
        bus.i_sustain = 8'h80;
        bus.i_gate   = 1'b1;
        do_pulse(1);
        for (int k = 1; k <= 256; k++) do_pulse(1);
        drain();
        check("attack_peak", {16'd0, last_sample}, 32'h7FFE);
        check("attack_to_decay", 32'(bus.o_state), 32'(DECAY));

        // Decay to sustain level 0x8080.
        n = 0;
        while (bus.o_state != SUSTAIN && n < 300) begin
            do_pulse(1);
            n++;
        end
        check("reach_sustain", 32'(bus.o_state), 32'(SUSTAIN));
        do_pulse(2);
        drain();
        check("sustain_ffff", {16'd0, last_sample}, 32'h403F);
        bus.i_sample = 16'h0000;
        do_pulse(2);
        drain();
        check("sustain_0000", {16'd0, last_sample}, 32'hBFC0);
        bus.i_sustain = 8'h40;
        do_pulse(2);
        drain();
        check("sustain_track", {16'd0, last_sample}, 32'hDFE0);
        bus.i_sustain = 8'h80;
        bus.i_sample  = 16'hFFFF;
        do_pulse(2);

        // Release by one per pulse, retrigger at 0x8000.
        bus.i_release = 8'd0;
        bus.i_gate    = 1'b0;
        do_pulse(2);
        check("enter_release", 32'(bus.o_state), 32'(RELEASE));
        repeat (128) do_pulse(2);
        bus.i_gate = 1'b1;
        do_pulse(2);
        drain();
        check("retrig_state", 32'(bus.o_state), 32'(ATTACK));
        check("retrig_level", {16'd0, last_sample}, 32'h3FFF);
        do_pulse(2);
        drain();
        check("retrig_step", {16'd0, last_sample}, 32'h407F);
        n = 0;
        while (bus.o_state != SUSTAIN && n < 400) begin
            do_pulse(1);
            n++;
        end
        check("resustain", 32'(bus.o_state), 32'(SUSTAIN));

        // Full release from 0x8080, pulses every 2 cycles.
        bus.i_gate = 1'b0;
        do_pulse(2);
        n = 0;
        while (bus.o_state != IDLE && n < 40000) begin
            do_pulse(2);
            n++;
        end
        check("release_pulses", n, 32'h8080);
        drain();
        check("release_busy", {31'd0, bus.o_busy}, 32'd0);
        check("release_sample", {16'd0, last_sample}, 32'd0);

        // Reset coincident with a pulse mid-attack.
        bus.i_gate = 1'b1;
        repeat (4) do_pulse(2);
        drain();
        check("pre_rst_state", 32'(bus.o_state), 32'(ATTACK));
        i_rst48     = 1'b1;
        bus.i_pulse = 1'b1;
        @(posedge i_clk48);
        #1;
        i_rst48     = 1'b0;
        bus.i_pulse = 1'b0;
        m_st  = IDLE;
        m_lvl = 0;
        sb.delete();
        check("mid_rst_state", 32'(bus.o_state), 32'(IDLE));
        check("mid_rst_busy", {31'd0, bus.o_busy}, 32'd0);
        repeat (4) begin
            check("mid_rst_no_valid", {31'd0, bus.o_valid}, 32'd0);
            @(posedge i_clk48);
            #1;
        end
        check("mid_rst_sample", {16'd0, bus.o_sample}, 32'd0);
        do_pulse(2);
        do_pulse(2);
        drain();
        check("post_rst_level", {16'd0, last_sample}, 32'd127);

        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
